// File: rtl/microcode_pipe.sv
// microcode_pipe: in-order N-stage carrier for decoded microcode words with per-stage holds,
// partial flush and retire counting. Define MICROCODE_PIPE_TAG_EN to attach a sequence tag to each word.

module microcode_stage #(
  parameter int WIDTH = 25,
  parameter int LSB   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             kill_i,
  input  logic             load_i,
  input  logic             move_i,
  input  logic [WIDTH-1:LSB] d_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] mc_o
);
  logic               valid_q, valid_d;
  logic [WIDTH-1:LSB] mc_q, mc_d;

  // Kill beats load: a flushed stage never captures the word arriving behind it.
  always_comb begin
    valid_d = valid_q;
    mc_d    = mc_q;
    if (kill_i) begin
      valid_d = 1'b0;
      mc_d    = '0;
    end else if (load_i) begin
      valid_d = 1'b1;
      mc_d    = d_i;
    end else if (move_i) begin
      valid_d = 1'b0;
      mc_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      mc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      mc_q    <= mc_d;
    end
  end

  assign valid_o = valid_q;

  always_comb begin
    mc_o            = '0;
    mc_o[WIDTH-1:LSB] = mc_q;
  end
endmodule

module microcode_pipe #(
  parameter int                      WIDTH      = 25,
  parameter int                      NUM_STAGES = 4,
  parameter logic [NUM_STAGES*8-1:0] STAGE_LSB  = {8'd22, 8'd15, 8'd10, 8'd0},
  parameter int                      CNT_W      = 32,
  parameter int                      TAG_W      = 4,
  localparam int                     FS_W       = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WIDTH-1:0]            in_mc,
  input  logic [NUM_STAGES-1:0]       stage_hold,
  input  logic                        flush,
  input  logic [FS_W-1:0]             flush_stage,
  output logic [NUM_STAGES-1:0]       stage_valid,
  output logic [NUM_STAGES*WIDTH-1:0] stage_mc,
  output logic                        retire,
  output logic [CNT_W-1:0]            retire_count,
  output logic [NUM_STAGES*TAG_W-1:0] stage_tag
);
  logic [NUM_STAGES-1:0]            mv, kill, load;
  logic [NUM_STAGES-1:0][WIDTH-1:0] mc;
  logic                             accept;
  logic [CNT_W-1:0]                 cnt_q, cnt_d;

  // Move chain resolved from the tail: a stage may advance only if the slot ahead frees up.
  always_comb begin
    logic nxt_free;
    mv       = '0;
    nxt_free = 1'b1;
    for (int k = NUM_STAGES-1; k >= 0; k--) begin
      mv[k]    = stage_valid[k] & ~stage_hold[k] & nxt_free;
      nxt_free = ~stage_valid[k] | mv[k];
    end
  end

  assign in_ready = ~flush & (~stage_valid[0] | mv[0]);
  assign accept   = in_valid & in_ready;

  always_comb begin
    kill = '0;
    load = '0;
    for (int k = 0; k < NUM_STAGES; k++)
      kill[k] = flush & (k <= int'(flush_stage));
    load[0] = accept;
    for (int k = 1; k < NUM_STAGES; k++)
      load[k] = mv[k-1] & ~kill[k-1];
  end

  assign retire = mv[NUM_STAGES-1] & ~kill[NUM_STAGES-1];

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    localparam int LSB = int'(STAGE_LSB[k*8 +: 8]);
    logic [WIDTH-1:LSB] src;
    if (k == 0) begin : g_head
      assign src = in_mc[WIDTH-1:LSB];
    end else begin : g_body
      assign src = mc[k-1][WIDTH-1:LSB];
    end
    microcode_stage #(.WIDTH(WIDTH), .LSB(LSB)) u_stage (
      .clk    (clk),
      .rst_n  (rst_n),
      .kill_i (kill[k]),
      .load_i (load[k]),
      .move_i (mv[k]),
      .d_i    (src),
      .valid_o(stage_valid[k]),
      .mc_o   (mc[k])
    );
    assign stage_mc[k*WIDTH +: WIDTH] = mc[k];
  end

  assign cnt_d = retire ? cnt_q + 1'b1 : cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign retire_count = cnt_q;

`ifdef MICROCODE_PIPE_TAG_EN
  logic [TAG_W-1:0]                 tag_cnt_q, tag_cnt_d;
  logic [NUM_STAGES-1:0][TAG_W-1:0] tag_q, tag_d, tag_src;

  // Tags shadow the valid/word movement; the issue counter keeps running across flushes.
  assign tag_src   = {tag_q[NUM_STAGES-2:0], tag_cnt_q};
  assign tag_cnt_d = accept ? tag_cnt_q + 1'b1 : tag_cnt_q;

  always_comb begin
    tag_d = tag_q;
    for (int k = 0; k < NUM_STAGES; k++) begin
      if (kill[k])      tag_d[k] = '0;
      else if (load[k]) tag_d[k] = tag_src[k];
      else if (mv[k])   tag_d[k] = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_cnt_q <= '0;
      tag_q     <= '0;
    end else begin
      tag_cnt_q <= tag_cnt_d;
      tag_q     <= tag_d;
    end
  end

  assign stage_tag = tag_q;
`else
  assign stage_tag = '0;
`endif
endmodule

// File: tb/tb_microcode_pipe.sv
// Randomised and directed bench for microcode_pipe against a stage-occupancy reference model.
module tb_microcode_pipe;
  localparam int N = 4, W = 25, CW = 32, TW = 4;
  localparam logic [N*8-1:0] LSB_P = {8'd22, 8'd15, 8'd10, 8'd0};
`ifdef MICROCODE_PIPE_TAG_EN
  localparam bit TAGEN = 1'b1;
`else
  localparam bit TAGEN = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, flush = 1'b0;
  logic in_ready, retire;
  logic [W-1:0] in_mc = '0;
  logic [N-1:0] stage_hold = '0;
  logic [1:0] flush_stage = '0;
  logic [N-1:0] stage_valid;
  logic [N*W-1:0] stage_mc;
  logic [CW-1:0] retire_count;
  logic [N*TW-1:0] stage_tag;
  int errors = 0, checks = 0;

  microcode_pipe #(.WIDTH(W), .NUM_STAGES(N), .STAGE_LSB(LSB_P), .CNT_W(CW), .TAG_W(TW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_mc(in_mc),
    .stage_hold(stage_hold), .flush(flush), .flush_stage(flush_stage),
    .stage_valid(stage_valid), .stage_mc(stage_mc), .retire(retire),
    .retire_count(retire_count), .stage_tag(stage_tag)
  );

  always #5 clk = ~clk;

  // Reference model: occupancy, word and tag per stage.
  logic [N-1:0] m_vld, m_adv;
  logic [W-1:0] m_w [N];
  logic [TW-1:0] m_t [N];
  logic [TW-1:0] m_tc;
  logic [CW-1:0] m_cnt;
  logic e_ready, e_retire, e_acc;
  logic [N*W-1:0] e_mc, e_vm;
  logic [N*TW-1:0] e_tag;
  logic [W-1:0] sbq [$];

  function automatic logic [W-1:0] msk(int k);
    logic [W-1:0] ones;
    ones = '1;
    return ones << LSB_P[k*8 +: 8];
  endfunction

  task automatic model_reset();
    m_vld = '0; m_tc = '0; m_cnt = '0;
    for (int k = 0; k < N; k++) begin m_w[k] = '0; m_t[k] = '0; end
  endtask

  task automatic model_eval();
    for (int k = N-1; k >= 0; k--) begin
      int j;
      j = (k == N-1) ? k : k + 1;
      m_adv[k] = m_vld[k] && !stage_hold[k] && (k == N-1 || !m_vld[j] || m_adv[j]);
    end
    e_ready  = !flush && (!m_vld[0] || m_adv[0]);
    e_retire = m_adv[N-1] && !(flush && int'(flush_stage) >= N-1);
    e_acc    = in_valid && e_ready;
    for (int k = 0; k < N; k++) begin
      e_mc[k*W +: W]   = m_w[k];
      e_vm[k*W +: W]   = {W{m_vld[k]}};
      e_tag[k*TW +: TW] = TAGEN ? m_t[k] : '0;
    end
  endtask

  task automatic model_commit();
    logic [N-1:0] nv;
    logic [W-1:0] nw [N];
    logic [TW-1:0] nt [N];
    for (int k = 0; k < N; k++) begin
      bit killed, takes;
      int j;
      j = (k == 0) ? 0 : k - 1;
      nv[k] = m_vld[k]; nw[k] = m_w[k]; nt[k] = m_t[k];
      killed = flush && k <= int'(flush_stage);
      if (k == 0) takes = e_acc;
      else        takes = m_adv[j] && !(flush && j <= int'(flush_stage));
      if (killed) begin
        nv[k] = 1'b0; nw[k] = '0; nt[k] = '0;
      end else if (takes) begin
        nv[k] = 1'b1;
        nw[k] = ((k == 0) ? in_mc : m_w[j]) & msk(k);
        nt[k] = (k == 0) ? m_tc : m_t[j];
      end else if (m_adv[k]) begin
        nv[k] = 1'b0; nw[k] = '0; nt[k] = '0;
      end
    end
    m_vld = nv;
    for (int k = 0; k < N; k++) begin m_w[k] = nw[k]; m_t[k] = nt[k]; end
    if (e_acc) m_tc = m_tc + 1'b1;
    if (e_retire) m_cnt = m_cnt + 1'b1;
  endtask

  // Called right after a falling edge: apply inputs and evaluate the model.
  task automatic drive(input logic v, input logic [W-1:0] d, input logic [N-1:0] h,
                       input logic f, input logic [1:0] fs);
    in_valid = v; in_mc = d; stage_hold = h; flush = f; flush_stage = fs;
    #1;
    model_eval();
  endtask

  task automatic step();
    @(posedge clk);
    model_commit();
    @(negedge clk);
  endtask

  task automatic test_reset();
    #12;
    checks++; if (stage_valid !== '0) begin errors++; $display("FAIL reset_valid: got %b want 0", stage_valid); end
    checks++; if (stage_mc !== '0) begin errors++; $display("FAIL reset_mc: got %h want 0", stage_mc); end
    checks++; if (retire_count !== '0) begin errors++; $display("FAIL reset_count: got %0d want 0", retire_count); end
    checks++; if (stage_tag !== '0) begin errors++; $display("FAIL reset_tag: got %h want 0", stage_tag); end
    checks++; if (in_ready !== 1'b1 || retire !== 1'b0) begin errors++; $display("FAIL reset_comb: got ready=%b retire=%b want 1/0", in_ready, retire); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_streaming();
    for (int c = 0; c < 10; c++) begin
      drive(c < 5, W'(c + 1), '0, 1'b0, 2'd0);
      checks++; if (retire !== (c >= 4 && c <= 8)) begin errors++; $display("FAIL stream_retire c%0d: got %b want %b", c, retire, (c >= 4 && c <= 8)); end
      checks++; if (stage_valid !== m_vld) begin errors++; $display("FAIL stream_valid c%0d: got %b want %b", c, stage_valid, m_vld); end
      checks++; if ((stage_mc & e_vm) !== e_mc) begin errors++; $display("FAIL stream_mc c%0d: got %h want %h", c, stage_mc & e_vm, e_mc); end
      if (stage_valid[3]) begin
        checks++; if (stage_mc[3*W +: 22] !== 22'd0) begin errors++; $display("FAIL stream_low_bits c%0d: got %h want 0", c, stage_mc[3*W +: 22]); end
      end
      step();
    end
    checks++; if (retire_count !== 32'd5) begin errors++; $display("FAIL stream_count: got %0d want 5", retire_count); end
  endtask

  task automatic test_hold();
    for (int c = 0; c < 18; c++) begin
      logic [N-1:0] h;
      h = (c >= 4 && c < 7) ? 4'b0100 : 4'b0000;
      drive(c < 9, W'($urandom), h, 1'b0, 2'd0);
      if (c == 4) begin
        checks++; if (stage_valid !== 4'hF) begin errors++; $display("FAIL hold_full: got %b want 1111", stage_valid); end
      end
      if (c >= 4 && c < 7) begin
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hold_ready c%0d: got %b want 0", c, in_ready); end
        checks++; if (retire !== (c == 4)) begin errors++; $display("FAIL hold_retire c%0d: got %b want %b", c, retire, c == 4); end
      end
      checks++; if (stage_valid !== m_vld || in_ready !== e_ready) begin errors++; $display("FAIL hold_model c%0d: got %b/%b want %b/%b", c, stage_valid, in_ready, m_vld, e_ready); end
      if (e_acc) sbq.push_back(in_mc);
      if (retire) begin
        logic [W-1:0] exp_w;
        exp_w = (sbq.size() > 0) ? sbq.pop_front() & msk(3) : '0;
        checks++; if (stage_mc[3*W +: W] !== exp_w) begin errors++; $display("FAIL hold_order c%0d: got %h want %h", c, stage_mc[3*W +: W], exp_w); end
      end
      step();
    end
    checks++; if (sbq.size() != 0 || stage_valid !== '0) begin errors++; $display("FAIL hold_drain: got %0d left valid=%b want 0", sbq.size(), stage_valid); end
    sbq.delete();
  endtask

  task automatic test_bubble();
    logic [W-1:0] b;
    b = W'($urandom);
    drive(1'b1, W'($urandom), '0, 1'b0, 2'd0); step();
    drive(1'b0, '0, '0, 1'b0, 2'd0); step();
    drive(1'b0, '0, '0, 1'b0, 2'd0); step();
    drive(1'b1, b, '0, 1'b0, 2'd0); step();
    for (int c = 0; c < 2; c++) begin
      drive(1'b0, '0, 4'b1000, 1'b0, 2'd0);
      if (c == 0) begin
        checks++; if (stage_valid !== 4'b1001) begin errors++; $display("FAIL bubble_start: got %b want 1001", stage_valid); end
      end
      checks++; if (in_ready !== 1'b1 || retire !== 1'b0) begin errors++; $display("FAIL bubble_comb c%0d: got %b/%b want 1/0", c, in_ready, retire); end
      step();
    end
    drive(1'b0, '0, '0, 1'b0, 2'd0);
    checks++; if (stage_valid !== 4'b1100) begin errors++; $display("FAIL bubble_valid: got %b want 1100", stage_valid); end
    checks++; if (stage_mc[2*W +: W] !== (b & msk(2))) begin errors++; $display("FAIL bubble_word: got %h want %h", stage_mc[2*W +: W], b & msk(2)); end
    for (int c = 0; c < 5; c++) begin drive(1'b0, '0, '0, 1'b0, 2'd0); step(); end
  endtask

  task automatic test_flush();
    logic [N-1:0] hs [3] = '{4'b1000, 4'b0100, 4'b0000};
    logic [N-1:0] ev [3] = '{4'b1100, 4'b0100, 4'b1000};
    for (int t = 0; t < 3; t++) begin
      for (int c = 0; c < 4; c++) begin drive(1'b1, W'($urandom), '0, 1'b0, 2'd0); step(); end
      drive(1'b1, W'($urandom), hs[t], 1'b1, 2'd1);
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_ready t%0d: got %b want 0", t, in_ready); end
      checks++; if (retire !== e_retire) begin errors++; $display("FAIL flush_retire t%0d: got %b want %b", t, retire, e_retire); end
      step();
      drive(1'b0, '0, '0, 1'b0, 2'd0);
      checks++; if (stage_valid !== ev[t]) begin errors++; $display("FAIL flush_valid t%0d: got %b want %b", t, stage_valid, ev[t]); end
      checks++; if (stage_mc[2*W-1:0] !== '0) begin errors++; $display("FAIL flush_zero t%0d: got %h want 0", t, stage_mc[2*W-1:0]); end
      checks++; if ((stage_mc & e_vm) !== e_mc || retire_count !== m_cnt) begin errors++; $display("FAIL flush_model t%0d: got %h/%0d want %h/%0d", t, stage_mc & e_vm, retire_count, e_mc, m_cnt); end
      step();
      for (int c = 0; c < 4; c++) begin drive(1'b0, '0, '0, 1'b0, 2'd0); step(); end
    end
  endtask

  task automatic test_flush_all();
    logic [CW-1:0] c0;
    for (int c = 0; c < 4; c++) begin drive(1'b1, W'($urandom), '0, 1'b0, 2'd0); step(); end
    drive(1'b1, W'($urandom), '0, 1'b1, 2'd3);
    c0 = retire_count;
    checks++; if (retire !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL flushall_comb: got retire=%b ready=%b want 0/0", retire, in_ready); end
    step();
    drive(1'b0, '0, '0, 1'b0, 2'd0);
    checks++; if (stage_valid !== '0 || stage_mc !== '0) begin errors++; $display("FAIL flushall_state: got %b %h want 0", stage_valid, stage_mc); end
    checks++; if (retire_count !== c0) begin errors++; $display("FAIL flushall_count: got %0d want %0d", retire_count, c0); end
    checks++; if (stage_tag !== '0) begin errors++; $display("FAIL flushall_tag: got %h want 0", stage_tag); end
    step();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      logic [N-1:0] h;
      for (int b = 0; b < N; b++) h[b] = ($urandom_range(4) == 0);
      drive($urandom_range(3) != 0, W'($urandom), h, $urandom_range(11) == 0, 2'($urandom_range(3)));
      checks++; if (in_ready !== e_ready || retire !== e_retire) begin errors++; $display("FAIL rand_comb c%0d: got %b/%b want %b/%b", c, in_ready, retire, e_ready, e_retire); end
      checks++; if (stage_valid !== m_vld) begin errors++; $display("FAIL rand_valid c%0d: got %b want %b", c, stage_valid, m_vld); end
      checks++; if ((stage_mc & e_vm) !== e_mc) begin errors++; $display("FAIL rand_mc c%0d: got %h want %h", c, stage_mc & e_vm, e_mc); end
      checks++; if (stage_tag !== e_tag || retire_count !== m_cnt) begin errors++; $display("FAIL rand_tag_cnt c%0d: got %h/%0d want %h/%0d", c, stage_tag, retire_count, e_tag, m_cnt); end
      step();
    end
    for (int c = 0; c < 6; c++) begin drive(1'b0, '0, '0, 1'b0, 2'd0); step(); end
  endtask

  task automatic test_async_reset();
    for (int c = 0; c < 3; c++) begin drive(1'b1, W'($urandom), '0, 1'b0, 2'd0); step(); end
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (stage_valid !== '0 || stage_mc !== '0) begin errors++; $display("FAIL areset_state: got %b %h want 0", stage_valid, stage_mc); end
    checks++; if (retire_count !== '0 || stage_tag !== '0) begin errors++; $display("FAIL areset_cnt_tag: got %0d %h want 0", retire_count, stage_tag); end
    model_reset();
    #1 rst_n = 1'b1;
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin drive(1'b1, W'(c + 1), '0, 1'b0, 2'd0); step(); end
    drive(1'b0, '0, '0, 1'b0, 2'd0);
    checks++; if (stage_tag[0 +: TW] !== (TAGEN ? 4'd4 : 4'd0)) begin errors++; $display("FAIL areset_tag5: got %0d want %0d", stage_tag[0 +: TW], TAGEN ? 4 : 0); end
    checks++; if (stage_tag[3*TW +: TW] !== (TAGEN ? 4'd1 : 4'd0)) begin errors++; $display("FAIL areset_tag2: got %0d want %0d", stage_tag[3*TW +: TW], TAGEN ? 1 : 0); end
    checks++; if (stage_tag !== e_tag || retire_count !== 32'd1) begin errors++; $display("FAIL areset_model: got %h/%0d want %h/1", stage_tag, retire_count, e_tag); end
    step();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_streaming();
    test_hold();
    test_bubble();
    test_flush();
    test_flush_all();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
